video_sync_monitor: RTL and testbench
=====================================

Name: video_sync_monitor

Overview:
- Downstream consumer of the Alice sync pads (PAD_HSYNC, PAD_VSYNC).
- Measures line period, HSYNC pulse width and lines per frame, all in CCK cycles, sampled on the CCK rising-edge strobe (C1[1]).
- Runs a lock FSM and flags timing errors, so simulation can check beam-counter output against PAL/NTSC timing without waveform inspection.

Parameters:
- LOCK_LINES, 4: consecutive in-range lines required to reach LOCKED.
- MIN_LINE, 200: minimum legal line length in CCK cycles.
- MAX_LINE, 240: maximum legal line length in CCK cycles; also the line timeout.
- PAL_THRESH, 288: frame_lines at or above this value sets pal_det.

Ports:
- main_clk  in  1  system clock; all logic on its rising edge.
- main_rst  in  1  asynchronous, active-high reset.
- cck_rise  in  1  one-main_clk strobe at each CCK rising edge; sole sampling enable.
- hsync_n  in  1  horizontal sync, active low.
- vsync_n  in  1  vertical sync, active low.
- line_len  out  9  length of last complete line, in CCK cycles.
- hs_width  out  8  last HSYNC low width, in CCK cycles (saturating).
- frame_lines  out  11  hs_fall count in last complete frame.
- pal_det  out  1  1 when last frame while LOCKED had frame_lines >= PAL_THRESH.
- locked  out  1  FSM is in LOCKED.
- line_strobe  out  1  one-cycle pulse when line_len updates.
- frame_strobe  out  1  one-cycle pulse when frame_lines updates.
- err_cnt  out  8  count of LOCKED-to-SEARCH drops, saturating at 255.

Behaviour:
- Reset: all outputs 0; internal counters 0; hs_q = vs_q = 1; FSM in SEARCH. Reset is async assert, with synchronous behaviour after release.
- All logic below acts only in main_clk cycles where cck_rise = 1. Otherwise all state holds and the strobes are 0.
- Edge detect: hs_q <= hsync_n and vs_q <= vsync_n.
  - hs_fall = hs_q & ~hsync_n; hs_rise = ~hs_q & hsync_n.
  - vs_fall = vs_q & ~vsync_n.
- h_cnt (9 bit):
  - On hs_fall: h_cnt <= 1.
  - Otherwise: h_cnt <= h_cnt + 1, saturating at 511.
- line_len update:
  - On hs_fall in MEASURE or LOCKED: line_len <= h_cnt and line_strobe = 1.
  - The first hs_fall in SEARCH only restarts h_cnt; it updates nothing.
- w_cnt (8 bit):
  - On hs_fall: w_cnt <= 1.
  - While hsync_n is low: w_cnt increments, saturating at 255.
  - On hs_rise: hs_width <= w_cnt.
- v_cnt (11 bit, saturating):
  - On vs_fall: frame_lines <= v_cnt, frame_strobe = 1, and v_cnt <= 1 if hs_fall occurs in the same strobe, else 0. Same-strobe hs_fall is counted in the new frame.
  - Otherwise: v_cnt increments on each hs_fall.
  - The first vs_fall after reset also updates frame_lines (partial frame).
  - pal_det updates on frame_strobe only while LOCKED.
- Latency: all outputs are registered and valid in the main_clk cycle after the cck_rise cycle that caused them.
- Lock FSM:
  - SEARCH: on hs_fall -> MEASURE, good <= 0.
  - MEASURE, on hs_fall:
    - If MIN_LINE <= h_cnt <= MAX_LINE: good <= good + 1. If good + 1 == LOCK_LINES -> LOCKED, locked = 1.
    - Otherwise: good <= 0, remain in MEASURE.
  - MEASURE timeout: h_cnt reaches MAX_LINE + 1 without hs_fall -> SEARCH.
  - LOCKED, either of the following -> SEARCH, locked <= 0, err_cnt <= err_cnt + 1 (saturating):
    - hs_fall with h_cnt out of range.
    - Timeout (h_cnt == MAX_LINE + 1).
  - line_len still updates with the offending value on that hs_fall.
- Simultaneous timeout and hs_fall in the same strobe: the hs_fall range check governs. h_cnt == MAX_LINE + 1 is out of range, so the result is still an error.
- Reset mid-operation clears everything, including err_cnt, pal_det and locked.

Test Plan:
- PAL lines, hsync_n low 17 CCK every 227 CCK, cck_rise every 8 main_clk -> line_len = 227, hs_width = 17; locked = 1 on the 5th hs_fall (4 measured lines); err_cnt = 0.
- NTSC alternating 227/228 lines, vsync_n fall every 262 lines -> stays locked; line_len alternates 227/228; frame_lines = 262; pal_det = 0. Repeat with PAL 312 lines -> pal_det = 1.
- Locked, then one 100-CCK line -> line_strobe with line_len = 100, locked = 0, err_cnt = 1; relock after 4 good lines.
- Locked, then hsync_n held high -> locked drops when h_cnt reaches 241; err_cnt increments once only; with cck_rise = 0 held, no state changes.
- hsync_n and vsync_n falling in the same cck_rise -> frame_lines = previous count; next frame count includes that line (e.g. 312 not 311).
- main_rst pulsed mid-frame while locked with err_cnt = 3 -> all outputs 0 immediately (async); normal lock after release.

Source files
------------

// File: rtl/video_sync_monitor.sv
// ---------------------------------------------------------------------------
// video_sync_monitor
//
// Watches the HSYNC/VSYNC pads driven by the beam counter and measures
// line period, HSYNC low width and lines per frame in CCK cycles. A lock FSM
// tracks whether the line timing sits inside the legal window, and the
// number of lock losses is counted so a bench can check raster timing
// directly instead of inspecting waveforms.
//
// Everything samples only in main_clk cycles where cck_rise is high; in other
// cycles all state holds and the strobes are low. All outputs are registered.
//
// Ports:
//   main_clk      in   1   system clock, rising edge
//   main_rst      in   1   asynchronous active-high reset
//   cck_rise      in   1   one-cycle strobe per CCK rising edge (sample enable)
//   hsync_n       in   1   horizontal sync, active low
//   vsync_n       in   1   vertical sync, active low
//   line_len      out  9   length of last complete line (CCK cycles)
//   hs_width      out  8   last HSYNC low width (CCK cycles, saturating)
//   frame_lines   out  11  hs_fall count of last complete frame
//   pal_det       out  1   last frame seen while locked was PAL length
//   locked        out  1   lock FSM is in LOCKED
//   line_strobe   out  1   pulse when line_len updates
//   frame_strobe  out  1   pulse when frame_lines updates
//   err_cnt       out  8   LOCKED-to-SEARCH drops, saturating at 255
// ---------------------------------------------------------------------------
module video_sync_monitor #(
    parameter int LOCK_LINES = 4,
    parameter int MIN_LINE   = 200,
    parameter int MAX_LINE   = 240,
    parameter int PAL_THRESH = 288
) (
    input  logic        main_clk,
    input  logic        main_rst,
    input  logic        cck_rise,
    input  logic        hsync_n,
    input  logic        vsync_n,
    output logic [8:0]  line_len,
    output logic [7:0]  hs_width,
    output logic [10:0] frame_lines,
    output logic        pal_det,
    output logic        locked,
    output logic        line_strobe,
    output logic        frame_strobe,
    output logic [7:0]  err_cnt
);

    localparam logic [8:0]  MIN_L     = 9'(MIN_LINE);
    localparam logic [8:0]  MAX_L     = 9'(MAX_LINE);
    localparam logic [8:0]  TIMEOUT_L = 9'(MAX_LINE + 1);
    localparam logic [10:0] PAL_L     = 11'(PAL_THRESH);
    localparam logic [7:0]  LOCK_N    = 8'(LOCK_LINES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  good_q, good_d;

    logic        hs_q, vs_q;
    logic [8:0]  h_cnt;
    logic [7:0]  w_cnt;
    logic [10:0] v_cnt;

    logic        hs_fall, hs_rise, vs_fall;
    logic        in_range, timeout, lock_drop;

    function automatic logic [8:0] inc_sat9(input logic [8:0] v);
        return (v == 9'h1FF) ? v : v + 9'd1;
    endfunction

    function automatic logic [7:0] inc_sat8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [10:0] inc_sat11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    // Edge events are qualified by the CCK strobe so nothing downstream
    // needs to re-check cck_rise.
    assign hs_fall  = cck_rise &  hs_q & ~hsync_n;
    assign hs_rise  = cck_rise & ~hs_q &  hsync_n;
    assign vs_fall  = cck_rise &  vs_q & ~vsync_n;
    assign in_range = (h_cnt >= MIN_L) && (h_cnt <= MAX_L);
    // A falling edge in the same strobe takes priority; h_cnt == MAX+1 is
    // then out of range and caught by the range check instead.
    assign timeout  = cck_rise && !hs_fall && (h_cnt == TIMEOUT_L);

    // Lock FSM: state register
    always_ff @(posedge main_clk or posedge main_rst) begin
        if (main_rst) begin
            state_q <= SEARCH;
            good_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    // Lock FSM: next state
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            SEARCH: begin
                if (hs_fall) begin
                    state_d = MEASURE;
                    good_d  = 8'd0;
                end
            end
            MEASURE: begin
                if (hs_fall) begin
                    if (in_range) begin
                        good_d = good_q + 8'd1;
                        if (good_q + 8'd1 == LOCK_N) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_d = 8'd0;
                    end
                end else if (timeout) begin
                    state_d = SEARCH;
                end
            end
            LOCKED: begin
                if ((hs_fall && !in_range) || timeout) begin
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Lock FSM: outputs
    always_comb begin
        locked = 1'b0;
        if (state_q == LOCKED) begin
            locked = 1'b1;
        end
    end

    assign lock_drop = (state_q == LOCKED) && (state_d == SEARCH);

    // Measurement datapath
    always_ff @(posedge main_clk or posedge main_rst) begin
        if (main_rst) begin
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            h_cnt        <= 9'd0;
            w_cnt        <= 8'd0;
            v_cnt        <= 11'd0;
            line_len     <= 9'd0;
            hs_width     <= 8'd0;
            frame_lines  <= 11'd0;
            pal_det      <= 1'b0;
            line_strobe  <= 1'b0;
            frame_strobe <= 1'b0;
            err_cnt      <= 8'd0;
        end else begin
            line_strobe  <= 1'b0;
            frame_strobe <= 1'b0;
            if (cck_rise) begin
                hs_q <= hsync_n;
                vs_q <= vsync_n;

                h_cnt <= hs_fall ? 9'd1 : inc_sat9(h_cnt);

                // The first edge out of SEARCH only restarts the count.
                if (hs_fall && (state_q != SEARCH)) begin
                    line_len    <= h_cnt;
                    line_strobe <= 1'b1;
                end

                if (hs_fall) begin
                    w_cnt <= 8'd1;
                end else if (!hsync_n) begin
                    w_cnt <= inc_sat8(w_cnt);
                end
                if (hs_rise) begin
                    hs_width <= w_cnt;
                end

                // A line starting in the same strobe as VSYNC belongs to
                // the new frame.
                if (vs_fall) begin
                    frame_lines  <= v_cnt;
                    frame_strobe <= 1'b1;
                    v_cnt        <= hs_fall ? 11'd1 : 11'd0;
                    if (state_q == LOCKED) begin
                        pal_det <= (v_cnt >= PAL_L);
                    end
                end else if (hs_fall) begin
                    v_cnt <= inc_sat11(v_cnt);
                end

                if (lock_drop) begin
                    err_cnt <= inc_sat8(err_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_video_sync_monitor.sv
module tb_video_sync_monitor;

    localparam int LOCK_LINES = 4;
    localparam int MIN_LINE   = 200;
    localparam int MAX_LINE   = 240;
    // Threshold scaled down so PAL/NTSC-style frames stay short.
    localparam int PAL_THRESH = 24;

    logic        main_clk = 1'b0;
    logic        main_rst;
    logic        cck_rise;
    logic        hsync_n;
    logic        vsync_n;
    logic [8:0]  line_len;
    logic [7:0]  hs_width;
    logic [10:0] frame_lines;
    logic        pal_det;
    logic        locked;
    logic        line_strobe;
    logic        frame_strobe;
    logic [7:0]  err_cnt;

    video_sync_monitor #(
        .LOCK_LINES (LOCK_LINES),
        .MIN_LINE   (MIN_LINE),
        .MAX_LINE   (MAX_LINE),
        .PAL_THRESH (PAL_THRESH)
    ) dut (
        .main_clk     (main_clk),
        .main_rst     (main_rst),
        .cck_rise     (cck_rise),
        .hsync_n      (hsync_n),
        .vsync_n      (vsync_n),
        .line_len     (line_len),
        .hs_width     (hs_width),
        .frame_lines  (frame_lines),
        .pal_det      (pal_det),
        .locked       (locked),
        .line_strobe  (line_strobe),
        .frame_strobe (frame_strobe),
        .err_cnt      (err_cnt)
    );

    always #5 main_clk = ~main_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: timestamps of sync edges in strobe units.
    int m_i, m_last_fall, m_fall_idx, m_frame, m_run;
    bit m_hsq, m_vsq, m_synced, m_lk;
    int e_line_len, e_hs_width, e_frame_lines, e_err;
    bit e_pal, e_ls, e_fs;

    typedef struct {
        bit cr;
        bit hs;
        bit vs;
        int line_len;
        int hs_width;
        int frame_lines;
        bit ls;
        bit fs;
    } vec_t;

    vec_t tbl[14];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [39:0] dut_vec();
        return {line_len, hs_width, frame_lines, pal_det, locked,
                line_strobe, frame_strobe, err_cnt};
    endfunction

    function automatic logic [39:0] exp_vec();
        return {9'(e_line_len), 8'(e_hs_width), 11'(e_frame_lines), e_pal, m_lk,
                e_ls, e_fs, 8'(e_err)};
    endfunction

    task automatic model_reset();
        m_i = 0; m_last_fall = 0; m_fall_idx = 0; m_frame = 0; m_run = 0;
        m_hsq = 1'b1; m_vsq = 1'b1; m_synced = 1'b0; m_lk = 1'b0;
        e_line_len = 0; e_hs_width = 0; e_frame_lines = 0; e_err = 0;
        e_pal = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
    endtask

    task automatic model_strobe(input bit hs, input bit vs);
        bit fall, rise, vfall, was_lk, was_synced, ok;
        int h;
        fall       = m_hsq && !hs;
        rise       = !m_hsq && hs;
        vfall      = m_vsq && !vs;
        h          = imin(m_i - m_last_fall, 511);
        was_lk     = m_lk;
        was_synced = m_synced;
        ok         = (h >= MIN_LINE) && (h <= MAX_LINE);

        if (rise) e_hs_width = imin(m_i - m_fall_idx, 255);
        if (fall) m_fall_idx = m_i;

        if (vfall) begin
            e_frame_lines = m_frame;
            e_fs = 1'b1;
            if (was_lk) e_pal = (m_frame >= PAL_THRESH);
            m_frame = fall ? 1 : 0;
        end else if (fall) begin
            m_frame = imin(m_frame + 1, 2047);
        end

        if (fall) begin
            m_last_fall = m_i;
            if (!was_synced) begin
                m_synced = 1'b1;
                m_run = 0;
            end else begin
                e_line_len = h;
                e_ls = 1'b1;
                if (ok) begin
                    if (!was_lk) begin
                        m_run++;
                        if (m_run == LOCK_LINES) m_lk = 1'b1;
                    end
                end else if (was_lk) begin
                    m_lk = 1'b0;
                    m_synced = 1'b0;
                    e_err = imin(e_err + 1, 255);
                end else begin
                    m_run = 0;
                end
            end
        end else if (was_synced && h == MAX_LINE + 1) begin
            if (was_lk) e_err = imin(e_err + 1, 255);
            m_lk = 1'b0;
            m_synced = 1'b0;
        end

        m_hsq = hs;
        m_vsq = vs;
        m_i++;
    endtask

    // One main_clk cycle; outputs checked against the model #1 after the edge.
    task automatic step(input bit cr, input bit hs, input bit vs);
        cck_rise = cr;
        hsync_n  = hs;
        vsync_n  = vs;
        @(posedge main_clk);
        e_ls = 1'b0;
        e_fs = 1'b0;
        if (cr) model_strobe(hs, vs);
        #1;
        chk("model", 64'(dut_vec()), 64'(exp_vec()));
    endtask

    task automatic strobe(input bit hs, input bit vs, input int gap);
        int g;
        g = (gap == 0) ? int'($urandom_range(1, 3)) : gap;
        step(1'b1, hs, vs);
        for (int k = 1; k < g; k++) step(1'b0, hs, vs);
    endtask

    task automatic send_line(input int len, input int low, input int vs_pos, input int gap);
        for (int k = 0; k < len; k++) begin
            strobe((k < low) ? 1'b0 : 1'b1, (k == vs_pos) ? 1'b0 : 1'b1, gap);
        end
    endtask

    task automatic send_frame(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            send_line((k % 2 == 1) ? 228 : 227, 17, (k == 0) ? 0 : -1, gap);
        end
    endtask

    task automatic do_reset();
        cck_rise = 1'b0;
        main_rst = 1'b1;
        repeat (3) @(posedge main_clk);
        #1;
        main_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 0, 2, 0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 0, 2, 1, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 4, 2, 1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 4, 1, 1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 2, 1, 1, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 2, 1, 1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 2, 1, 1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 2, 1, 1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 3, 1, 2, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 3, 1, 2, 1'b0, 1'b0};

        hsync_n = 1'b1;
        vsync_n = 1'b1;
        do_reset();
        chk("reset_state", 64'(dut_vec()), 64'd0);

        // Short edge/counter vectors straight after reset.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].cr, tbl[i].hs, tbl[i].vs);
            chk($sformatf("vec%0d", i),
                64'({line_len, hs_width, frame_lines, line_strobe, frame_strobe}),
                64'({9'(tbl[i].line_len), 8'(tbl[i].hs_width), 11'(tbl[i].frame_lines),
                     tbl[i].ls, tbl[i].fs}));
        end

        // PAL lines, CCK strobe every 8 clocks.
        do_reset();
        for (int i = 0; i < 4; i++) send_line(227, 17, -1, 8);
        chk("pal_not_yet_locked", 64'(locked), 64'd0);
        send_line(227, 17, -1, 8);
        chk("pal_locked", 64'(locked), 64'd1);
        chk("pal_line_len", 64'(line_len), 64'd227);
        chk("pal_hs_width", 64'(hs_width), 64'd17);
        chk("pal_err", 64'(err_cnt), 64'd0);

        // Short (NTSC-style) frames then a long (PAL-style) frame.
        send_frame(20, 1);
        send_frame(20, 1);
        send_frame(26, 1);
        chk("ntsc_frame_lines", 64'(frame_lines), 64'd20);
        chk("ntsc_pal_det", 64'(pal_det), 64'd0);
        chk("ntsc_line_len", 64'(line_len), 64'd227);
        chk("ntsc_locked", 64'(locked), 64'd1);
        send_line(227, 17, 0, 1);
        chk("pal_frame_lines", 64'(frame_lines), 64'd26);
        chk("pal_det_set", 64'(pal_det), 64'd1);
        chk("alt_line_len", 64'(line_len), 64'd228);

        // One short line while locked, then relock.
        send_line(100, 17, -1, 1);
        send_line(227, 17, -1, 1);
        chk("short_line_len", 64'(line_len), 64'd100);
        chk("short_unlocked", 64'(locked), 64'd0);
        chk("short_err", 64'(err_cnt), 64'd1);
        for (int i = 0; i < 4; i++) send_line(227, 17, -1, 1);
        chk("relock_pending", 64'(locked), 64'd0);
        send_line(227, 17, -1, 1);
        chk("relocked", 64'(locked), 64'd1);

        // hsync_n held high: timeout when h_cnt reaches MAX_LINE+1.
        strobe(1'b0, 1'b1, 1);
        for (int i = 0; i < 16; i++) strobe(1'b0, 1'b1, 1);
        for (int i = 0; i < 224; i++) strobe(1'b1, 1'b1, 1);
        chk("pre_timeout_locked", 64'(locked), 64'd1);
        strobe(1'b1, 1'b1, 1);
        chk("timeout_unlocked", 64'(locked), 64'd0);
        chk("timeout_err", 64'(err_cnt), 64'd2);
        for (int i = 0; i < 300; i++) strobe(1'b1, 1'b1, 1);
        chk("timeout_err_once", 64'(err_cnt), 64'd2);
        for (int i = 0; i < 40; i++) step(1'b0, 1'($urandom), 1'($urandom));
        chk("idle_err_hold", 64'(err_cnt), 64'd2);
        chk("idle_line_len_hold", 64'(line_len), 64'd227);

        // Build err_cnt up to 3 while locked, then reset mid-frame.
        for (int i = 0; i < 5; i++) send_line(227, 17, -1, 1);
        chk("lock_again", 64'(locked), 64'd1);
        send_line(100, 17, -1, 1);
        send_line(227, 17, -1, 1);
        for (int i = 0; i < 5; i++) send_line(227, 17, -1, 1);
        for (int k = 0; k < 60; k++) strobe((k < 17) ? 1'b0 : 1'b1, 1'b1, 1);
        chk("pre_reset_err", 64'(err_cnt), 64'd3);
        chk("pre_reset_locked", 64'(locked), 64'd1);
        cck_rise = 1'b0;
        main_rst = 1'b1;
        #2;
        chk("async_reset", 64'(dut_vec()), 64'd0);
        repeat (2) @(posedge main_clk);
        #1;
        main_rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) send_line(227, 17, -1, 1);
        chk("post_reset_locked", 64'(locked), 64'd1);
        chk("post_reset_err", 64'(err_cnt), 64'd0);

        // Very long HSYNC pulse saturates the width counter.
        send_line(300, 280, -1, 1);
        chk("width_sat", 64'(hs_width), 64'd255);

        // Randomized line lengths, pulse widths, VSYNC placement and strobe gaps.
        for (int i = 0; i < 30; i++) begin
            int len, low, vpos;
            len  = ($urandom_range(0, 9) < 7) ? int'($urandom_range(215, 235))
                                              : int'($urandom_range(150, 260));
            low  = int'($urandom_range(1, 40));
            vpos = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            send_line(len, low, vpos, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
